// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: response FSM states and
// the owner tag carried with an outstanding transaction.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Counts consecutive data grants taken while fetch is waiting; saturates at
// STARVE_LIMIT so the arbiter can force one fetch grant.
module starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_count;

    // Clear has priority; increment stops at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CW{1'b0}};
        end else if (i_clr) begin
            r_count <= {CW{1'b0}};
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-cycle SRAM: data has priority
// unless fetch has been starved, one transaction per cycle, one-cycle response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SIZE          = 12,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDRESS_WIDTH-1:0]  i_addr,
    output logic                      i_gnt,
    output logic                      i_rvalid,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_err,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    input  logic [ADDRESS_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    output logic                      d_gnt,
    output logic                      d_rvalid,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [SIZE-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int BW   = DATA_WIDTH / 8;
    localparam int CW   = $clog2(STARVE_LIMIT + 1);
    localparam int HI_W = ADDRESS_WIDTH - SIZE - 2;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic          w_i_in_range;
    logic          w_d_in_range;
    logic          w_starved;
    logic          w_i_gnt;
    logic          w_d_gnt;
    logic [CW-1:0] w_count;
    logic          w_unused_addr_bits;

    state_e        r_state;
    owner_e        r_owner;
    logic          r_err;
    logic          r_wr;
    logic          r_i_rvalid;
    logic          r_d_rvalid;
    logic          r_i_err;
    logic          r_d_err;

    assign w_i_in_range       = (i_addr[ADDRESS_WIDTH-1:SIZE+2] == {HI_W{1'b0}});
    assign w_d_in_range       = (d_addr[ADDRESS_WIDTH-1:SIZE+2] == {HI_W{1'b0}});
    assign w_starved          = i_req && (w_count == LIMIT);
    assign w_unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_d_gnt && i_req),
        .i_clr   (w_i_gnt || !i_req),
        .o_count (w_count)
    );

    // Grant selection: starved fetch first, then data, then fetch.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (rst) begin
            w_i_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end else if (w_starved) begin
            w_i_gnt = 1'b1;
        end else if (d_req) begin
            w_d_gnt = 1'b1;
        end else if (i_req) begin
            w_i_gnt = 1'b1;
        end else begin
            w_i_gnt = 1'b0;
        end
    end

    // Memory port mirrors the granted requester; out-of-range grants leave it idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = {BW{1'b0}};
        mem_addr  = {SIZE{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        if (w_d_gnt && w_d_in_range) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr[SIZE+1:2];
            mem_wdata = d_wdata;
        end else if (w_i_gnt && w_i_in_range) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr[SIZE+1:2];
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Response FSM and outstanding-transaction tags; next state follows this cycle's grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_I;
            r_err      <= 1'b0;
            r_wr       <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_err    <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            r_i_rvalid <= w_i_gnt;
            r_d_rvalid <= w_d_gnt;
            r_i_err    <= w_i_gnt && !w_i_in_range;
            r_d_err    <= w_d_gnt && !w_d_in_range;
            if (w_i_gnt) begin
                r_state <= RESP_I;
                r_owner <= OWN_I;
                r_err   <= !w_i_in_range;
                r_wr    <= 1'b0;
            end else if (w_d_gnt) begin
                r_state <= RESP_D;
                r_owner <= OWN_D;
                r_err   <= !w_d_in_range;
                r_wr    <= d_we;
            end else begin
                r_state <= IDLE;
                r_owner <= r_owner;
                r_err   <= 1'b0;
                r_wr    <= 1'b0;
            end
        end
    end

    // Read data passes straight from memory to the owner of the pending read.
    always_comb begin
        i_rdata = {DATA_WIDTH{1'b0}};
        d_rdata = {DATA_WIDTH{1'b0}};
        case (r_state)
            RESP_I: begin
                if ((r_owner == OWN_I) && !r_err) begin
                    i_rdata = mem_rdata;
                end else begin
                    i_rdata = {DATA_WIDTH{1'b0}};
                end
            end
            RESP_D: begin
                if ((r_owner == OWN_D) && !r_err && !r_wr) begin
                    d_rdata = mem_rdata;
                end else begin
                    d_rdata = {DATA_WIDTH{1'b0}};
                end
            end
            default: begin
                i_rdata = {DATA_WIDTH{1'b0}};
                d_rdata = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign i_err    = r_i_err;
    assign d_err    = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SZ    = 12;
    localparam int SL    = 4;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << SZ;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [BW-1:0] mem_be;
    logic [SZ-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(SZ), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM device behind the arbiter
    logic [DW-1:0] tb_mem  [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= tb_mem[mem_addr];
            end
        end
    end

    // Transaction-level reference model, evaluated mid-cycle
    int            m_cnt = 0;
    bit            p_iv = 0, p_ie = 0, p_dv = 0, p_de = 0;
    logic [DW-1:0] p_id = '0, p_dd = '0;
    bit            e_ig = 0, e_dg = 0;
    bit            m_ig, m_dg, m_iin, m_din, x_en, x_we;
    int            m_iw, m_dw;
    logic [BW-1:0] x_be;
    logic [SZ-1:0] x_addr;
    logic [DW-1:0] x_wd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_mem_en", mem_en, 0);
            m_cnt = 0; p_iv = 0; p_dv = 0; e_ig = 0; e_dg = 0;
        end else begin
            m_dg  = d_req && !((m_cnt == SL) && i_req);
            m_ig  = i_req && !m_dg;
            m_iin = (i_addr >> (SZ + 2)) == 0;
            m_din = (d_addr >> (SZ + 2)) == 0;
            m_iw  = int'((i_addr >> 2) % DEPTH);
            m_dw  = int'((d_addr >> 2) % DEPTH);
            chk("i_gnt", i_gnt, m_ig);
            chk("d_gnt", d_gnt, m_dg);
            x_en = 0; x_we = 0; x_be = '0; x_addr = '0; x_wd = '0;
            if (m_dg && m_din) begin
                x_en = 1; x_we = d_we; x_be = d_be; x_addr = SZ'(m_dw); x_wd = d_wdata;
            end else if (m_ig && m_iin) begin
                x_en = 1; x_addr = SZ'(m_iw);
            end
            chk("mem_en", mem_en, x_en);
            chk("mem_we", mem_we, x_we);
            chk("mem_be", mem_be, x_be);
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_wdata", mem_wdata, x_wd);
            chk("i_rvalid", i_rvalid, p_iv);
            chk("d_rvalid", d_rvalid, p_dv);
            if (p_iv) begin
                chk("i_err", i_err, p_ie);
                chk("i_rdata", i_rdata, p_id);
            end
            if (p_dv) begin
                chk("d_err", d_err, p_de);
                chk("d_rdata", d_rdata, p_dd);
            end
            p_iv = m_ig; p_ie = m_ig && !m_iin;
            p_id = (m_ig && m_iin) ? ref_mem[m_iw] : '0;
            p_dv = m_dg; p_de = m_dg && !m_din;
            p_dd = (m_dg && m_din && !d_we) ? ref_mem[m_dw] : '0;
            if (m_dg && m_din && d_we)
                for (int b = 0; b < BW; b++)
                    if (d_be[b]) ref_mem[m_dw][8*b +: 8] = d_wdata[8*b +: 8];
            if (m_ig || !i_req) m_cnt = 0;
            else if (m_dg && m_cnt < SL) m_cnt = m_cnt + 1;
            e_ig = m_ig; e_dg = m_dg;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom) | 32'h0000_4000;
        return AW'($urandom_range(0, 63));
    endfunction

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            tb_mem[k]  = 32'hA500_0000 | k;
            ref_mem[k] = 32'hA500_0000 | k;
        end
        repeat (3) @(posedge clk);
        smp();
        chk("rst_state", dut.r_state, IDLE);
        chk("rst_count", dut.w_count, 0);
        cyc(); rst = 1'b0;

        // fetch only
        i_req = 1'b1; i_addr = 32'h10;
        smp(); chk("f_gnt", i_gnt, 1); chk("f_mem_addr", mem_addr, 4);
        cyc(); i_req = 1'b0;
        smp(); chk("f_rvalid", i_rvalid, 1); chk("f_rdata", i_rdata, 32'hA500_0004); chk("f_err", i_err, 0);

        // data write
        cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_be = 4'h3; d_wdata = 32'hDEAD_BEEF;
        smp(); chk("w_we", mem_we, 1); chk("w_be", mem_be, 4'h3); chk("w_addr", mem_addr, 2);
        cyc(); d_req = 1'b0; d_we = 1'b0;
        smp(); chk("w_rvalid", d_rvalid, 1); chk("w_rdata", d_rdata, 0);

        // simultaneous requests
        cyc(); i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_addr = 32'h20;
        smp(); chk("s_dgnt", d_gnt, 1); chk("s_ignt0", i_gnt, 0); chk("s_addr_d", mem_addr, 8);
        cyc(); d_req = 1'b0;
        smp(); chk("s_ignt", i_gnt, 1); chk("s_drvalid", d_rvalid, 1);
        chk("s_drdata", d_rdata, 32'hA500_0008);
        cyc(); i_req = 1'b0;
        smp(); chk("s_irvalid", i_rvalid, 1); chk("s_irdata", i_rdata, 32'hA500_0005);

        // read back the partial write
        cyc(); d_req = 1'b1; d_addr = 32'h8;
        smp();
        cyc(); d_req = 1'b0;
        smp(); chk("rb_rdata", d_rdata, 32'hA500_BEEF);

        // starvation
        cyc(); i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'hC;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("st_dgnt", d_gnt, (k < 4) ? 1 : 0);
            chk("st_ignt", i_gnt, (k < 4) ? 0 : 1);
            if (k < 4) cyc();
        end
        cyc(); i_req = 1'b0;
        smp(); chk("st_clear", dut.w_count, 0); chk("st_dgnt_after", d_gnt, 1);
        cyc(); d_req = 1'b0;

        // out of range fetch
        i_req = 1'b1; i_addr = 32'h4000;
        smp(); chk("oor_gnt", i_gnt, 1); chk("oor_mem_en", mem_en, 0);
        cyc(); i_req = 1'b0;
        smp(); chk("oor_rvalid", i_rvalid, 1); chk("oor_err", i_err, 1); chk("oor_rdata", i_rdata, 0);

        // reset while a response is pending
        cyc(); i_req = 1'b1; i_addr = 32'h18;
        smp(); chk("rp_gnt", i_gnt, 1);
        cyc(); rst = 1'b1; i_req = 1'b0;
        smp(); chk("rp_rvalid", i_rvalid, 0); chk("rp_state", dut.r_state, IDLE); chk("rp_count", dut.w_count, 0);
        cyc(); rst = 1'b0;
        smp(); chk("rp_rvalid_after", i_rvalid, 0); chk("rp_state_after", dut.r_state, IDLE);

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (!i_req || e_ig) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = rnd_addr();
            end
            if (!d_req || e_dg) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_be    = BW'($urandom);
                d_addr  = rnd_addr();
                d_wdata = DW'($urandom);
            end
        end
        cyc(); i_req = 1'b0; d_req = 1'b0; rst = 1'b0;
        repeat (3) smp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 The module SHALL have parameter SIZE, default 12, log2 of memory depth in words.
REQ-004 The module SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while fetch waits.
REQ-005 The module SHALL have these ports:
  clk  in  1  the single clock; all state changes on the rising edge.
  rst  in  1  asynchronous, active-high reset.
  i_req  in  1  fetch read request; held with i_addr until i_gnt.
  i_addr  in  ADDRESS_WIDTH  fetch byte address.
  i_gnt  out  1  fetch request accepted this cycle.
  i_rvalid  out  1  fetch response valid.
  i_rdata  out  DATA_WIDTH  fetch read data.
  i_err  out  1  fetch address out of range, qualified by i_rvalid.
  d_req  in  1  data request; held with d_* inputs until d_gnt.
  d_we  in  1  1 = write, 0 = read.
  d_be  in  DATA_WIDTH/8  write byte enables.
  d_addr  in  ADDRESS_WIDTH  data byte address.
  d_wdata  in  DATA_WIDTH  write data.
  d_gnt  out  1  data request accepted this cycle.
  d_rvalid  out  1  data response or write completion.
  d_rdata  out  DATA_WIDTH  data read data (0 for writes).
  d_err  out  1  data address out of range, qualified by d_rvalid.
  mem_en  out  1  memory access strobe.
  mem_we  out  1  memory write enable.
  mem_be  out  DATA_WIDTH/8  memory byte enables.
  mem_addr  out  SIZE  word index = selected addr[SIZE+1:2].
  mem_wdata  out  DATA_WIDTH  memory write data.
  mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en.

Function
REQ-006 At most one of i_gnt, d_gnt SHALL be high in any cycle; a grant SHALL be issued combinationally in the cycle the winning request is present.
REQ-007 Arbitration SHALL favour data over fetch, except when the starvation counter equals STARVE_LIMIT and i_req is high, in which case fetch SHALL win.
REQ-008 The starvation counter SHALL increment on each d_gnt while i_req is high, clear on i_gnt or when i_req is low, and saturate at STARVE_LIMIT.
REQ-009 On a grant with in-range address (addr[ADDRESS_WIDTH-1:SIZE+2] == 0), mem_en SHALL be 1 and mem_we, mem_be, mem_addr, mem_wdata SHALL reflect the granted requester (mem_we = 0, mem_be = 0 for fetch).
REQ-010 On a grant with out-of-range address, mem_en SHALL be 0, and the response the next cycle SHALL carry rdata = 0 and err = 1.
REQ-011 Response latency SHALL be exactly one cycle: the rvalid of the granted requester SHALL be high in the cycle after its grant, with rdata = mem_rdata for reads.
REQ-012 A new grant SHALL be allowed in the same cycle a response is returned, giving throughput of one transaction per cycle.
REQ-013 The FSM SHALL have states IDLE (no response pending), RESP_I (fetch response pending) and RESP_D (data response pending); the next state SHALL be set by the grant issued this cycle, else IDLE.
REQ-014 Outstanding-transaction tags (owner, err) SHALL be registered; rdata SHALL pass combinationally from mem_rdata.
REQ-015 When no request is present, all mem_* outputs SHALL be 0.

Reset
REQ-016 On rst, the state SHALL be IDLE, the starvation counter 0, and i_rvalid, d_rvalid, i_err, d_err 0 immediately (asynchronously).
REQ-017 A response pending when rst asserts SHALL be discarded and never presented after rst deasserts.
REQ-018 No grant SHALL be issued while rst is high.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the state enum (IDLE, RESP_I, RESP_D) and the owner enum (OWN_I, OWN_D).
REQ-020 The starvation counter SHALL be a sub-module starve_counter parameterised by STARVE_LIMIT.

Verification
REQ-021 Fetch only: i_req, i_addr = 0x10 -> i_gnt and mem_addr = 4 the same cycle; next cycle i_rvalid = 1, i_rdata = mem_rdata, i_err = 0.
REQ-022 Simultaneous i_req and d_req (read 0x20) -> d_gnt first; fetch is granted the next cycle; both responses return one cycle after their grants.
REQ-023 Starvation: i_req held with d_req continuous -> after 4 d_gnt, the 5th cycle grants fetch; the counter then clears.
REQ-024 Data write d_addr = 0x8, d_be = 0x3, d_wdata = 0xDEADBEEF -> mem_we = 1, mem_be = 0x3, mem_addr = 2; next cycle d_rvalid = 1, d_rdata = 0.
REQ-025 Out of range: i_addr = 0x4000 with SIZE = 12 -> i_gnt = 1, mem_en = 0; next cycle i_rvalid = 1, i_err = 1, i_rdata = 0.
REQ-026 Assert rst in the cycle after a grant -> no rvalid is seen; state is IDLE after reset and the counter is 0.
